serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial WIDTH-bit subtractor computing A − B, LSB first, one bit per clock. It wraps the team's 1-bit `fs` full-subtractor cell with a borrow flip-flop, operand shift registers and a control FSM. It sits directly upstream of any consumer needing a registered difference and final borrow.

## Interface

Parameters:
- `WIDTH`, default 8: operand width; legal range ≥ 2.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `start`: input, 1 bit. Request an operation; sampled only in IDLE.
- `a_in`: input, WIDTH bits. Minuend; captured on the accepted `start`.
- `b_in`: input, WIDTH bits. Subtrahend; captured on the accepted `start`.
- `busy`: output, 1 bit. High while in SHIFT or DONE.
- `done`: output, 1 bit. One-cycle pulse; `diff` and `borrow_out` are valid from this cycle.
- `diff`: output, WIDTH bits. Result A − B, modulo 2^WIDTH.
- `borrow_out`: output, 1 bit. Final borrow; 1 when A < B (unsigned).

## Operation

- FSM has three states: IDLE, SHIFT, DONE.
- **IDLE → SHIFT** when `start` = 1:
  - load shift register `a_sr` ← `a_in` and `b_sr` ← `b_in`;
  - clear the borrow flop `brw` ← 0 and `cnt` ← 0;
  - clear the working register `d_sr`.
- **SHIFT**, each cycle:
  - drive `fs` inputs with `a` = `a_sr[0]`, `b` = `b_sr[0]`, `bin` = `brw`;
  - `d_sr` ← {`d`, `d_sr[WIDTH-1:1]`}, i.e. the new bit enters at the MSB and the register shifts right;
  - `brw` ← `bout`;
  - `a_sr` and `b_sr` shift right by one;
  - `cnt` increments.
- **SHIFT → DONE** on the cycle where `cnt` = WIDTH−1. That last bit is still processed in this cycle.
- **DONE**, single cycle:
  - `done` = 1;
  - `diff` and `borrow_out` are updated from `d_sr` and `brw` on entry to DONE;
  - then return to IDLE.
- `diff` and `borrow_out` hold their values until the next DONE. A new `start` does not clear them.
- `start` in SHIFT or DONE is ignored; there is no queueing.
- `cnt` width is $clog2(WIDTH). It never wraps within an operation.
- Arithmetic is unsigned. {`borrow_out`, `diff`} equals the (WIDTH+1)-bit two's-complement of A − B.

## Timing

- Reset values: state IDLE; `busy` 0, `done` 0, `diff` 0, `borrow_out` 0. Internal registers (`a_sr`, `b_sr`, `d_sr`, `brw`, `cnt`) are all 0.
- `rst` overrides every other input on the same edge. A reset mid-operation aborts it: no `done` is produced and `diff` returns to 0.
- Latency: with `start` accepted at edge N, `busy` is high from N, and `done` is high in the cycle after edge N+WIDTH, i.e. WIDTH+1 cycles after the start edge.
- Throughput: one operation per WIDTH+2 cycles, because IDLE takes at least one cycle between operations.
- `done` and `busy` are registered outputs; neither is combinational from `start`.
- `start` held high continuously: a new operation starts on the first IDLE cycle after each DONE.

## Structure

- Package `serial_sub_pkg` holds:
  - the state enum `sub_state_t` (IDLE, SHIFT, DONE);
  - the constant `SUB_WIDTH_DEFAULT` = 8.
- The single natural sub-module is the existing `fs` cell (ports `a`, `b`, `bin`, `d`, `bout`), instantiated once. No other hierarchy.

## Test plan

- WIDTH=8, `a_in`=5, `b_in`=3, pulse `start` → `done` pulse 9 cycles later; `diff`=0x02, `borrow_out`=0.
- `a_in`=3, `b_in`=5 → `diff`=0xFE, `borrow_out`=1.
- `a_in`=0x00, `b_in`=0x00, then `a_in`=0xFF, `b_in`=0x01 back-to-back with `start` held high → `diff`=0x00 with `borrow_out`=0, then `diff`=0xFE with `borrow_out`=0; exactly two `done` pulses, 10 cycles apart.
- `start` with `a_in`=0x10, `b_in`=0x20; pulse `start` again with different operands 3 cycles later → second pulse ignored; `diff`=0xF0, `borrow_out`=1; one `done` only.
- Assert `rst` 4 cycles into an operation → the next cycle shows state IDLE, `busy`=0, `diff`=0, and no `done` follows.
- Random sweep, 200 operand pairs → every result matches the (WIDTH+1)-bit reference model of A − B.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_subtractor_fs.sv
// 1-bit full subtractor: d = a - b - bin, bout set when that underflows.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock, around a single fs cell.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);

  sub_state_t       state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             d, bout;
  logic             last;

  fs u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .d    (d),
    .bout (bout)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      d_sr       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
      case (state)
        IDLE: if (start) begin
          a_sr <= a_in;
          b_sr <= b_in;
          d_sr <= '0;
          brw  <= 1'b0;
          cnt  <= '0;
        end
        SHIFT: begin
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          d_sr <= {d, d_sr[WIDTH-1:1]};
          brw  <= bout;
          // Final bit is folded straight into the outputs so they are valid with done.
          if (last) begin
            diff       <= {d, d_sr[WIDTH-1:1]};
            borrow_out <= bout;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: vector table, multi-cycle corner sequences, random sweep.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W   = 8;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic [W-1:0] exp_diff;
    logic         exp_brw;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Start one operation from IDLE, wait for done, leave the DUT in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] rd, output logic rb, output int lat);
    a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    rd = diff; rb = borrow_out;
    if (!done) lat = -1;
    @(negedge clk);
    chk("done_single_pulse", done, 1'b0);
  endtask

  vec_t         tbl[8];
  logic [W-1:0] rd;
  logic         rb;
  int           lat;
  logic [W:0]   ref9;
  int           ndone, t1, t2;
  logic [W-1:0] d1, d2;
  logic         b1, b2;

  initial begin
    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
    tbl[4] = '{8'h10, 8'h20, 8'hF0, 1'b1};
    tbl[5] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    tbl[6] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    tbl[7] = '{8'hFF, 8'hFF, 8'h00, 1'b0};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_diff", diff, 8'h00);
    chk("reset_borrow", borrow_out, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, rd, rb, lat);
      chk($sformatf("vec%0d_latency", i), lat, LAT);
      chk($sformatf("vec%0d_diff", i), rd, tbl[i].exp_diff);
      chk($sformatf("vec%0d_borrow", i), rb, tbl[i].exp_brw);
      chk($sformatf("vec%0d_hold", i), diff, tbl[i].exp_diff);
    end

    // Outputs survive a new start until the next done.
    a_in = 8'h44; b_in = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("diff_held_during_op", diff, 8'h00);
    repeat (LAT) @(negedge clk);
    chk("op_diff_0x33", diff, 8'h33);

    // Start held high: back-to-back operations.
    a_in = 8'h00; b_in = 8'h00; start = 1'b1;
    ndone = 0; t1 = -1; t2 = -1; d1 = '0; d2 = '0; b1 = 1'b0; b2 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin a_in = 8'hFF; b_in = 8'h01; end
      if (k == 11) start = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) begin t1 = k; d1 = diff; b1 = borrow_out; end
        if (ndone == 2) begin t2 = k; d2 = diff; b2 = borrow_out; end
      end
    end
    chk("b2b_done_count", ndone, 2);
    chk("b2b_first_at", t1, LAT);
    chk("b2b_spacing", t2 - t1, W + 2);
    chk("b2b_diff1", d1, 8'h00);
    chk("b2b_brw1", b1, 1'b0);
    chk("b2b_diff2", d2, 8'hFE);
    chk("b2b_brw2", b2, 1'b0);

    // A second start while shifting is dropped.
    a_in = 8'h10; b_in = 8'h20; start = 1'b1;
    ndone = 0; t1 = -1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (k == 3) begin a_in = 8'h55; b_in = 8'h11; end
      if (done) begin ndone++; t1 = k; d1 = diff; b1 = borrow_out; end
    end
    chk("ign_done_count", ndone, 1);
    chk("ign_done_at", t1, LAT);
    chk("ign_diff", d1, 8'hF0);
    chk("ign_brw", b1, 1'b1);
    start = 1'b0;

    // Reset mid-operation aborts it.
    a_in = 8'hA0; b_in = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", dut.state, IDLE);
    chk("abort_busy", busy, 1'b0);
    chk("abort_diff", diff, 8'h00);
    chk("abort_borrow", borrow_out, 1'b0);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);

    // Random sweep against plain (W+1)-bit arithmetic.
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rbv;
      ra  = W'($urandom);
      rbv = W'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rbv};
      run_op(ra, rbv, rd, rb, lat);
      chk($sformatf("rnd%0d_latency", i), lat, LAT);
      chk($sformatf("rnd%0d_result a=%0h b=%0h", i, ra, rbv), {rb, rd}, ref9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
